// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable NCH-channel 50%-duty clock divider running on clk_25M.
// Define CLK_DIV_TICK_EN to build the per-channel one-cycle tick strobes; otherwise tick is tied low.
module clk_div_prog #(
    parameter int NCH      = 8,
    parameter int CW       = 25,
    parameter int HALF_RST = 12499
) (
    input  logic            clk_25M,
    input  logic            reset,
    input  logic [NCH-1:0]  ch_en,
    input  logic            sync,
    input  logic            wr_en,
    input  logic [3:0]      wr_ch,
    input  logic [CW-1:0]   wr_data,
    input  logic [3:0]      rd_ch,
    output logic [CW-1:0]   rd_data,
    output logic [NCH-1:0]  clk_out,
    output logic [NCH-1:0]  tick
);

    localparam logic [CW-1:0] HALF_RST_C = CW'(HALF_RST);
    localparam logic [CW-1:0] ONE_C      = CW'(1);
    localparam logic [CW-1:0] ZERO_C     = {CW{1'b0}};

    logic [CW-1:0]  cnt_r     [NCH];
    logic [CW-1:0]  act_r     [NCH];
    logic [CW-1:0]  pnd_r     [NCH];
    logic [CW-1:0]  cnt_nxt_s [NCH];
    logic [CW-1:0]  act_nxt_s [NCH];
    logic [CW-1:0]  pnd_nxt_s [NCH];
    logic [NCH-1:0] clk_r;
    logic [NCH-1:0] clk_nxt_s;
    logic [NCH-1:0] wrap_s;
    logic [NCH-1:0] restart_s;
    logic [CW-1:0]  rd_sel_s;
    logic [CW-1:0]  rd_data_r;

    // Per-channel next state; act only ever changes while cnt is forced to 0, so the >= compare stays safe.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            restart_s[i] = ~ch_en[i] | sync;
            wrap_s[i]    = (cnt_r[i] >= act_r[i]);
            pnd_nxt_s[i] = (wr_en && (wr_ch == 4'(i))) ? wr_data : pnd_r[i];
            cnt_nxt_s[i] = cnt_r[i];
            act_nxt_s[i] = act_r[i];
            clk_nxt_s[i] = clk_r[i];
            if (restart_s[i]) begin
                cnt_nxt_s[i] = ZERO_C;
                act_nxt_s[i] = pnd_nxt_s[i];
                clk_nxt_s[i] = 1'b0;
            end else if (wrap_s[i]) begin
                cnt_nxt_s[i] = ZERO_C;
                act_nxt_s[i] = pnd_nxt_s[i];
                clk_nxt_s[i] = ~clk_r[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + ONE_C;
            end
        end
    end

    // Read-back mux; channels beyond NCH read as zero.
    always_comb begin
        rd_sel_s = ZERO_C;
        for (int i = 0; i < NCH; i++) begin
            rd_sel_s = (rd_ch == 4'(i)) ? act_r[i] : rd_sel_s;
        end
    end

    // Channel state, clock outputs and read-back register.
    always_ff @(posedge clk_25M) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= ZERO_C;
                act_r[i] <= HALF_RST_C;
                pnd_r[i] <= HALF_RST_C;
            end
            clk_r     <= {NCH{1'b0}};
            rd_data_r <= ZERO_C;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
                act_r[i] <= act_nxt_s[i];
                pnd_r[i] <= pnd_nxt_s[i];
            end
            clk_r     <= clk_nxt_s;
            rd_data_r <= rd_sel_s;
        end
    end

    assign clk_out = clk_r;
    assign rd_data = rd_data_r;

`ifdef CLK_DIV_TICK_EN
    logic [NCH-1:0] tick_r;
    logic [NCH-1:0] tick_nxt_s;

    // Tick fires together with each 0->1 toggle of clk_out.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            tick_nxt_s[i] = ~restart_s[i] & wrap_s[i] & ~clk_r[i];
        end
    end

    // Tick register.
    always_ff @(posedge clk_25M) begin
        if (reset) begin
            tick_r <= {NCH{1'b0}};
        end else begin
            tick_r <= tick_nxt_s;
        end
    end

    assign tick = tick_r;
`else
    assign tick = {NCH{1'b0}};
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: stimulus pushes expected toggle edges, read-backs and
// zero-state checks keyed by cycle number; a negedge monitor pops and compares them.
module tb_clk_div_prog;

    localparam int NCH = 8;
    localparam int CW  = 25;
    localparam int END_CYC = 64300;

    localparam int K_TOG  = 0;
    localparam int K_RD   = 1;
    localparam int K_ZALL = 2;
    localparam int K_ZCH  = 3;

    typedef struct {
        int cyc;
        int ch;
        int kind;
        int val;
    } ev_t;

    logic           clk_25M;
    logic           reset;
    logic [NCH-1:0] ch_en;
    logic           sync;
    logic           wr_en;
    logic [3:0]     wr_ch;
    logic [CW-1:0]  wr_data;
    logic [3:0]     rd_ch;
    logic [CW-1:0]  rd_data;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    int             cyc;
    int             checks;
    int             failures;
    ev_t            sb_q[$];
    ev_t            ev;
    logic [NCH-1:0] prev_clk;
    logic [NCH-1:0] exp_chg;
    logic [NCH-1:0] exp_tick;

    clk_div_prog dut (
        .clk_25M (clk_25M),
        .reset   (reset),
        .ch_en   (ch_en),
        .sync    (sync),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_data (wr_data),
        .rd_ch   (rd_ch),
        .rd_data (rd_data),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial begin
        clk_25M = 1'b0;
        forever #5 clk_25M = ~clk_25M;
    end

    initial cyc = 0;
    always @(posedge clk_25M) cyc <= cyc + 1;

    function automatic int bit_of(input logic [NCH-1:0] v, input int ch);
        return int'((v >> ch) & NCH'(1));
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic push(input int c, input int ch, input int kind, input int val);
        ev_t e;
        e.cyc  = c;
        e.ch   = ch;
        e.kind = kind;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    // Expected toggles of one channel: first at 'first' to level v0, then every 'half' cycles.
    task automatic sched(input int ch, input int first, input int v0, input int half, input int last);
        int v;
        v = v0;
        for (int c = first; c <= last; c += half) begin
            push(c, ch, K_TOG, v);
            v = 1 - v;
        end
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) @(negedge clk_25M);
    endtask

    task automatic do_write(input int ch, input int data);
        wr_en   = 1'b1;
        wr_ch   = 4'(ch);
        wr_data = CW'(data);
        @(negedge clk_25M);
        wr_en   = 1'b0;
    endtask

    // Monitor: pop every entry due this cycle, then check toggle set and tick strobes.
    always @(negedge clk_25M) begin
        exp_chg = '0;
        if (cyc >= 2) begin
            for (int k = sb_q.size() - 1; k >= 0; k--) begin
                if (sb_q[k].cyc == cyc) begin
                    ev = sb_q[k];
                    sb_q.delete(k);
                    case (ev.kind)
                        K_TOG: begin
                            exp_chg = exp_chg | (NCH'(1) << ev.ch);
                            chk($sformatf("tog_level_ch%0d", ev.ch), bit_of(clk_out, ev.ch), ev.val);
                        end
                        K_RD:   chk("rd_data", int'(rd_data), ev.val);
                        K_ZALL: chk("zero_all", int'({tick, clk_out}), 0);
                        K_ZCH:  chk($sformatf("zero_ch%0d", ev.ch),
                                    bit_of(clk_out, ev.ch) + bit_of(tick, ev.ch), 0);
                        default: chk("bad_kind", ev.kind, 0);
                    endcase
                end
            end
            chk("toggle_set", int'(clk_out ^ prev_clk), int'(exp_chg));
`ifdef CLK_DIV_TICK_EN
            exp_tick = clk_out & ~prev_clk;
`else
            exp_tick = '0;
`endif
            chk("tick", int'(tick), int'(exp_tick));
        end
        prev_clk = clk_out;
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        ch_en    = '1;
        sync     = 1'b0;
        wr_en    = 1'b0;
        wr_ch    = 4'd0;
        wr_data  = '0;
        rd_ch    = 4'd0;
        push(2, 0, K_ZALL, 0);
        push(2, 0, K_RD, 0);

        // Reset released after edge 3: default half 12499 toggles every 12500 cycles.
        goto_cyc(3);
        reset = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (ch != 2) sched(ch, 12503, 1, 12500, 50100);
        end
        push(100, 0, K_RD, 12499);
        goto_cyc(200);
        rd_ch = 4'd5;
        push(201, 0, K_RD, 12499);
        goto_cyc(300);
        rd_ch = 4'd12;
        push(301, 0, K_RD, 0);

        // ch2 retuned mid-period: finishes its 12500 half, then halves of 125.
        goto_cyc(5000);
        do_write(2, 124);
        sched(2, 12503, 1, 125, 50100);
        goto_cyc(6000);
        rd_ch = 4'd2;
        push(6001, 0, K_RD, 12499);
        push(13001, 0, K_RD, 124);

        // Pending write followed by a one-cycle reset: the write is lost, act back to 12499.
        goto_cyc(50050);
        do_write(2, 50);
        goto_cyc(50100);
        reset = 1'b1;
        push(50101, 0, K_ZALL, 0);
        push(50101, 2, K_TOG, 0);
        push(50101, 0, K_RD, 0);
        push(50102, 0, K_RD, 12499);
        @(negedge clk_25M);
        reset = 1'b0;
        for (int ch = 0; ch < NCH; ch++) sched(ch, 62601, 1, 12500, 62601);

        // Write ch0=0 on its wrap edge: write-through gives toggling every cycle.
        goto_cyc(62600);
        do_write(0, 0);
        sched(0, 62602, 0, 1, 62701);
        goto_cyc(62650);
        rd_ch = 4'd0;
        push(62651, 0, K_RD, 0);
        goto_cyc(62700);
        do_write(0, 124);
        sched(0, 62826, 0, 125, 63000);
        goto_cyc(62702);
        do_write(1, 1249);
        goto_cyc(62704);
        do_write(3, 99);

        // Sync: every channel low on the same edge, then restarts from its pending half.
        goto_cyc(63000);
        sync = 1'b1;
        for (int ch = 0; ch < NCH; ch++) push(63001, ch, K_TOG, 0);
        sched(0, 63126, 1, 125, END_CYC);
        sched(1, 64251, 1, 1250, END_CYC);
        sched(3, 63101, 1, 100, 63150);
        @(negedge clk_25M);
        sync = 1'b0;

        // ch3 dropped mid-high for 10 cycles; first rise act+1 cycles after re-enable.
        goto_cyc(63150);
        ch_en[3] = 1'b0;
        push(63151, 3, K_TOG, 0);
        for (int c = 63151; c <= 63160; c++) push(c, 3, K_ZCH, 0);
        goto_cyc(63160);
        ch_en[3] = 1'b1;
        sched(3, 63260, 1, 100, END_CYC);

        // Out-of-range write must not reach any channel; disabling ch4 exposes its pending value.
        goto_cyc(63170);
        do_write(12, 5);
        goto_cyc(63180);
        ch_en[4] = 1'b0;
        goto_cyc(63185);
        rd_ch = 4'd4;
        push(63186, 0, K_RD, 12499);
        push(63186, 4, K_ZCH, 0);
        goto_cyc(63190);
        rd_ch = 4'd3;
        push(63191, 0, K_RD, 99);
        goto_cyc(63195);
        rd_ch = 4'd1;
        push(63196, 0, K_RD, 1249);

        goto_cyc(END_CYC + 2);
        chk("sb_drain", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
